mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/riscv_pipe_pkg.sv | 62 ++++++
 rtl/store_align.sv | 47 ++++
 rtl/mem_stage.sv | 196 +++++++++++++++++++
 tb/tb_mem_stage.sv | 548 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions: bus widths, field offsets, codes
// for wb_sel / csr_cmd / exceptions, and the store FSM encoding.
package riscv_pipe_pkg;

  localparam int EXE_MEM_W = 190;
  localparam int MEM_WB_W  = 70;
  localparam int MEM_ID_W  = 38;
  localparam int EXC_W     = 6;

  // exe_mem bus field offsets (LSB of each field)
  localparam int OFF_ALU      = 158;
  localparam int OFF_RD       = 153;
  localparam int OFF_RD_WEN   = 152;
  localparam int OFF_MEM_WE   = 151;
  localparam int OFF_MEM_RE   = 150;
  localparam int OFF_WB_SEL   = 147;
  localparam int OFF_PC       = 115;
  localparam int OFF_WB_DATA  = 83;
  localparam int OFF_CSR_CMD  = 79;
  localparam int OFF_CSR_ADDR = 67;
  localparam int OFF_OP1      = 35;
  localparam int OFF_RDATA    = 3;
  localparam int OFF_SIZE     = 0;

  localparam logic [2:0] WB_ALU = 3'b001;
  localparam logic [2:0] WB_MEM = 3'b010;
  localparam logic [2:0] WB_PC4 = 3'b011;
  localparam logic [2:0] WB_CSR = 3'b100;

  localparam logic [3:0] CSR_W = 4'b1000;
  localparam logic [3:0] CSR_S = 4'b0100;
  localparam logic [3:0] CSR_C = 4'b0010;

  localparam logic [5:0] EXC_ST_MISALIGN = 6'b100110;
  localparam logic [5:0] EXC_ST_FAULT    = 6'b100111;

  localparam logic [31:0] ST_ADDR_LIMIT = 32'h6000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } st_state_e;

  // Field order matches the offsets above, MSB first.
  typedef struct packed {
    logic [31:0] alu_result;
    logic [4:0]  rd;
    logic        rd_wen;
    logic        mem_we;
    logic        mem_re;
    logic [2:0]  wb_sel;
    logic [31:0] exe_pc;
    logic [31:0] wb_data;
    logic [3:0]  csr_cmd;
    logic [11:0] csr_addr;
    logic [31:0] op1_data;
    logic [31:0] mem_rdata_ext;
    logic [2:0]  mem_size;
  } exe_mem_t;

endpackage

// File: rtl/store_align.sv
// Store lane alignment: byte strobes, replicated write data and
// misalignment flag from address and size.
// Ports: i_addr, i_data, i_size -> o_strb, o_data, o_misaligned.
module store_align (
  input  logic [31:0] i_addr,
  input  logic [31:0] i_data,
  input  logic [1:0]  i_size,
  output logic [3:0]  o_strb,
  output logic [31:0] o_data,
  output logic        o_misaligned
);

  logic w_word;
  logic w_byte;
  logic w_half;
  logic w_unused_addr;

  assign w_word = !i_size[0];
  assign w_byte = i_size[0] && i_size[1];
  assign w_half = i_size[0] && !i_size[1];

  assign w_unused_addr = ^i_addr[31:2];

  always_comb begin
    o_strb       = 4'b1111;
    o_data       = i_data;
    o_misaligned = 1'b0;
    unique case (1'b1)
      w_byte: begin
        o_strb = 4'b0001 << i_addr[1:0];
        o_data = {4{i_data[7:0]}};
      end
      w_half: begin
        o_strb       = 4'b0011 << {i_addr[1], 1'b0};
        o_data       = {2{i_data[15:0]}};
        o_misaligned = i_addr[0];
      end
      w_word: begin
        o_strb       = 4'b1111;
        o_data       = i_data;
        o_misaligned = |i_addr[1:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: latches the EXE bus, issues stores over a
// req/ack port, selects writeback value, raises store exceptions.
// Ports: clk/rst; exe_mem_bus_in + es_to_ms_valid/ms_allowin in;
// mem_wb_bus_out + ms_to_ws_valid/ws_allowin out; mem_id_data_bus
// forwarding; dmem_* store port; csr_* write port; exception
// codes in/out; exception_stalled flush.
module mem_stage
  import riscv_pipe_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [EXE_MEM_W-1:0] exe_mem_bus_in,
  input  logic                 es_to_ms_valid,
  output logic                 ms_allowin,
  output logic                 ms_to_ws_valid,
  input  logic                 ws_allowin,
  output logic [MEM_WB_W-1:0]  mem_wb_bus_out,
  output logic [MEM_ID_W-1:0]  mem_id_data_bus,
  output logic                 dmem_wreq,
  output logic [31:0]          dmem_waddr,
  output logic [31:0]          dmem_wdata,
  output logic [3:0]           dmem_wstrb,
  input  logic                 dmem_wack,
  output logic                 csr_we,
  output logic [11:0]          csr_waddr,
  output logic [31:0]          csr_wdata,
  input  logic [EXC_W-1:0]     exception_code_em,
  output logic [EXC_W-1:0]     exception_code_mw,
  input  logic                 exception_stalled
);

  logic             r_valid;
  exe_mem_t         r_bus;
  logic [EXC_W-1:0] r_exc;
  logic             r_flush;
  st_state_e        r_state;
  st_state_e        w_state_nxt;

  logic             w_ready_go;
  logic             w_leave;
  logic             w_store_pend;
  logic             w_flush_req;
  logic             w_discard;
  logic             w_no_exc;
  logic             w_misal;
  logic             w_fault;
  logic             w_rd_wen;
  logic [EXC_W-1:0] w_exc;
  logic [31:0]      w_wb_value;
  logic [31:0]      w_csr_wdata;
  logic [3:0]       w_strb;
  logic [31:0]      w_sdata;
  logic             w_unused_ok;

  assign w_unused_ok = ^{r_bus.mem_re, r_bus.mem_size[2]};

  store_align u_align (
    .i_addr       (r_bus.alu_result),
    .i_data       (r_bus.wb_data),
    .i_size       (r_bus.mem_size[1:0]),
    .o_strb       (w_strb),
    .o_data       (w_sdata),
    .o_misaligned (w_misal)
  );

  assign w_fault = r_bus.mem_we &&
                   (r_bus.alu_result > ST_ADDR_LIMIT);

  // Upstream exception wins, then misaligned, then access fault.
  always_comb begin
    w_exc = '0;
    if (r_valid) begin
      if (r_exc[5])
        w_exc = r_exc;
      else if (r_bus.mem_we && w_misal)
        w_exc = EXC_ST_MISALIGN;
      else if (w_fault)
        w_exc = EXC_ST_FAULT;
    end
  end

  assign w_no_exc     = (w_exc == '0);
  assign w_store_pend = r_valid && r_bus.mem_we && w_no_exc;

  assign w_ready_go = !((r_state == ST_IDLE && w_store_pend) ||
                        (r_state == ST_REQ));

  assign ms_allowin     = !r_valid || (w_ready_go && ws_allowin);
  assign ms_to_ws_valid = r_valid && w_ready_go;
  assign w_leave        = ms_to_ws_valid && ws_allowin;

  // A flush seen mid-request is remembered until the ack so the
  // memory side always completes its handshake.
  assign w_flush_req = (r_state == ST_REQ) &&
                       (exception_stalled || r_flush);
  assign w_discard   = (exception_stalled && r_state != ST_REQ) ||
                       (w_flush_req && dmem_wack);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_store_pend && !exception_stalled)
          w_state_nxt = ST_REQ;
      end
      ST_REQ: begin
        if (dmem_wack)
          w_state_nxt = w_flush_req ? ST_IDLE : ST_DONE;
      end
      ST_DONE: begin
        if (w_leave || exception_stalled)
          w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flush <= 1'b0;
    end else if (r_state == ST_REQ) begin
      if (dmem_wack)
        r_flush <= 1'b0;
      else if (exception_stalled)
        r_flush <= 1'b1;
    end else begin
      r_flush <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_bus   <= '0;
      r_exc   <= '0;
    end else if (w_discard) begin
      r_valid <= 1'b0;
      r_bus   <= '0;
      r_exc   <= '0;
    end else if (ms_allowin) begin
      r_valid <= es_to_ms_valid;
      if (es_to_ms_valid) begin
        r_bus <= exe_mem_t'(exe_mem_bus_in);
        r_exc <= exception_code_em;
      end
    end
  end

  always_comb begin
    w_wb_value = '0;
    case (r_bus.wb_sel)
      WB_ALU:  w_wb_value = r_bus.alu_result;
      WB_MEM:  w_wb_value = r_bus.mem_rdata_ext;
      WB_PC4:  w_wb_value = r_bus.exe_pc + 32'd4;
      WB_CSR:  w_wb_value = r_bus.alu_result;
      default: w_wb_value = '0;
    endcase
  end

  // alu_result carries the old CSR value for CSR instructions.
  always_comb begin
    w_csr_wdata = '0;
    case (r_bus.csr_cmd)
      CSR_W:   w_csr_wdata = r_bus.op1_data;
      CSR_S:   w_csr_wdata = r_bus.alu_result | r_bus.op1_data;
      CSR_C:   w_csr_wdata = r_bus.alu_result & ~r_bus.op1_data;
      default: w_csr_wdata = '0;
    endcase
  end

  assign w_rd_wen = r_valid && r_bus.rd_wen && w_no_exc;

  assign mem_wb_bus_out  = {w_wb_value, r_bus.rd,
                            w_rd_wen, r_bus.exe_pc};
  assign mem_id_data_bus = {w_wb_value, w_rd_wen, r_bus.rd};

  assign dmem_wreq  = (r_state == ST_REQ);
  assign dmem_waddr = dmem_wreq ?
                      {r_bus.alu_result[31:2], 2'b00} : '0;
  assign dmem_wdata = dmem_wreq ? w_sdata : '0;
  assign dmem_wstrb = dmem_wreq ? w_strb : '0;

  assign csr_we    = w_leave && (r_bus.csr_cmd != '0) && w_no_exc;
  assign csr_waddr = r_bus.csr_addr;
  assign csr_wdata = w_csr_wdata;

  assign exception_code_mw = w_exc;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized scoreboard bench for mem_stage plus directed cases
// for store timing, exceptions, CSR pulse, stalls and flushes.
module tb_mem_stage;
  import riscv_pipe_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic [189:0] exe_mem_bus_in;
  logic         es_to_ms_valid;
  logic         ms_allowin;
  logic         ms_to_ws_valid;
  wire          ws_allowin;
  logic [69:0]  mem_wb_bus_out;
  logic [37:0]  mem_id_data_bus;
  logic         dmem_wreq;
  logic [31:0]  dmem_waddr;
  logic [31:0]  dmem_wdata;
  logic [3:0]   dmem_wstrb;
  logic         dmem_wack;
  logic         csr_we;
  logic [11:0]  csr_waddr;
  logic [31:0]  csr_wdata;
  logic [5:0]   exception_code_em;
  logic [5:0]   exception_code_mw;
  logic         exception_stalled;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk               (clk),
    .rst               (rst),
    .exe_mem_bus_in    (exe_mem_bus_in),
    .es_to_ms_valid    (es_to_ms_valid),
    .ms_allowin        (ms_allowin),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ws_allowin        (ws_allowin),
    .mem_wb_bus_out    (mem_wb_bus_out),
    .mem_id_data_bus   (mem_id_data_bus),
    .dmem_wreq         (dmem_wreq),
    .dmem_waddr        (dmem_waddr),
    .dmem_wdata        (dmem_wdata),
    .dmem_wstrb        (dmem_wstrb),
    .dmem_wack         (dmem_wack),
    .csr_we            (csr_we),
    .csr_waddr         (csr_waddr),
    .csr_wdata         (csr_wdata),
    .exception_code_em (exception_code_em),
    .exception_code_mw (exception_code_mw),
    .exception_stalled (exception_stalled)
  );

  typedef struct {
    logic [69:0] wb;
    logic [37:0] id;
    logic [5:0]  exc;
    logic        cwe;
    logic [11:0] caddr;
    logic [31:0] cdata;
  } ho_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } st_t;

  ho_t ho_q[$];
  st_t st_q[$];

  int checks = 0;
  int failures = 0;
  int ack_fixed = -1;
  bit rand_ws = 0;
  logic ws_force = 1'b1;
  logic ws_rand = 1'b1;

  assign ws_allowin = rand_ws ? ws_rand : ws_force;

  task automatic chk(input string nm, input logic [69:0] act,
                     input logic [69:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference behaviour written from the stage's rules.
  function automatic void model(input exe_mem_t b,
                                input logic [5:0] em,
                                output ho_t h, output bit st,
                                output st_t s);
    logic [31:0] a;
    logic [31:0] v;
    logic [5:0]  e;
    logic        rdw;
    bit          wrd, byt, hlf;
    a   = b.alu_result;
    wrd = (b.mem_size[0] == 1'b0);
    byt = b.mem_size[0] && b.mem_size[1];
    hlf = b.mem_size[0] && !b.mem_size[1];
    e = 6'd0;
    if (em[5])
      e = em;
    else if (b.mem_we && ((wrd && a % 4 != 0) ||
                          (hlf && a % 2 != 0)))
      e = 6'b100110;
    else if (b.mem_we && a > 32'h6000_0000)
      e = 6'b100111;
    case (b.wb_sel)
      3'b001:  v = a;
      3'b010:  v = b.mem_rdata_ext;
      3'b011:  v = b.exe_pc + 32'd4;
      3'b100:  v = a;
      default: v = 32'd0;
    endcase
    rdw     = b.rd_wen && (e == 6'd0);
    h.wb    = {v, b.rd, rdw, b.exe_pc};
    h.id    = {v, rdw, b.rd};
    h.exc   = e;
    h.cwe   = (b.csr_cmd != 4'd0) && (e == 6'd0);
    h.caddr = b.csr_addr;
    case (b.csr_cmd)
      4'b1000: h.cdata = b.op1_data;
      4'b0100: h.cdata = a | b.op1_data;
      4'b0010: h.cdata = a & ~b.op1_data;
      default: h.cdata = 32'd0;
    endcase
    st     = b.mem_we && (e == 6'd0);
    s.addr = a - (a % 4);
    if (byt) begin
      s.strb = 4'(1 << (a % 4));
      s.data = {4{b.wb_data[7:0]}};
    end else if (hlf) begin
      s.strb = ((a % 4) >= 2) ? 4'b1100 : 4'b0011;
      s.data = {2{b.wb_data[15:0]}};
    end else begin
      s.strb = 4'b1111;
      s.data = b.wb_data;
    end
  endfunction

  task automatic send(input exe_mem_t b, input logic [5:0] em,
                      input bit exp_ho);
    ho_t h;
    st_t s;
    bit  st;
    bit  ok;
    exe_mem_bus_in    = b;
    exception_code_em = em;
    es_to_ms_valid    = 1'b1;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ms_allowin) begin
        ok = 1;
        break;
      end
    end
    if (ok) begin
      model(b, em, h, st, s);
      if (exp_ho) ho_q.push_back(h);
      if (st) st_q.push_back(s);
    end else begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got allowin=0 want 1");
    end
    @(posedge clk);
    #1;
    es_to_ms_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Random downstream backpressure.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      ws_rand = ($urandom_range(0, 3) != 0);
    end
  end

  // Store acknowledge responder.
  initial begin
    int acnt;
    int lat;
    acnt = 0;
    lat = 0;
    dmem_wack = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (dmem_wreq) begin
        if (acnt == 0)
          lat = (ack_fixed >= 0) ? ack_fixed :
                int'($urandom_range(0, 4));
        acnt++;
        dmem_wack = (acnt > lat);
      end else begin
        dmem_wack = 1'b0;
        acnt = 0;
      end
    end
  end

  // Scoreboard monitor.
  initial begin
    ho_t h;
    st_t cur;
    bit  prev_wreq;
    prev_wreq = 0;
    cur = '{default: '0};
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_wreq = 0;
      end else begin
        if (ms_to_ws_valid && ws_allowin) begin
          if (ho_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL extra_handoff: got 1 want 0");
          end else begin
            h = ho_q.pop_front();
            chk("wb_bus", mem_wb_bus_out, h.wb);
            chk("id_bus", mem_id_data_bus, h.id);
            chk("exc_mw", exception_code_mw, h.exc);
            chk("csr_we", csr_we, h.cwe);
            if (h.cwe) begin
              chk("csr_waddr", csr_waddr, h.caddr);
              chk("csr_wdata", csr_wdata, h.cdata);
            end
          end
        end else begin
          chk("csr_we_idle", csr_we, 1'b0);
        end
        if (dmem_wreq) begin
          if (!prev_wreq) begin
            if (st_q.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL extra_wreq: got 1 want 0");
            end else begin
              cur = st_q.pop_front();
            end
          end
          chk("waddr", dmem_waddr, cur.addr);
          chk("wdata", dmem_wdata, cur.data);
          chk("wstrb", dmem_wstrb, cur.strb);
        end
        prev_wreq = dmem_wreq;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic exe_mem_t gen();
    exe_mem_t b;
    int k;
    int r;
    b = '0;
    b.alu_result    = $urandom;
    b.rd            = 5'($urandom);
    b.rd_wen        = 1'($urandom);
    b.exe_pc        = $urandom;
    b.wb_data       = $urandom;
    b.op1_data      = $urandom;
    b.mem_rdata_ext = $urandom;
    b.mem_size      = 3'($urandom);
    b.csr_addr      = 12'($urandom);
    k = $urandom_range(0, 5);
    case (k)
      0: b.wb_sel = 3'b001;
      1: begin
        b.wb_sel = 3'b010;
        b.mem_re = 1'b1;
      end
      2: b.wb_sel = 3'b011;
      3: begin
        b.wb_sel = 3'b100;
        r = $urandom_range(0, 2);
        b.csr_cmd = (r == 0) ? 4'b1000 :
                    (r == 1) ? 4'b0100 : 4'b0010;
      end
      4: begin
        b.mem_we = 1'b1;
        b.rd_wen = 1'b0;
        b.wb_sel = 3'b000;
        r = $urandom_range(0, 4);
        case (r)
          0: b.alu_result = 32'h6000_0000;
          1: b.alu_result = 32'h6000_0004;
          2: b.alu_result = $urandom;
          default: b.alu_result = $urandom & 32'h0FFF_FFFF;
        endcase
      end
      default: begin
        r = $urandom_range(0, 3);
        b.wb_sel = (r == 0) ? 3'b000 :
                   (r == 1) ? 3'b101 :
                   (r == 2) ? 3'b110 : 3'b111;
      end
    endcase
    return b;
  endfunction

  function automatic logic [5:0] gen_em();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 6'h20 | 6'($urandom_range(0, 31));
    if (r == 1) return 6'($urandom_range(1, 31));
    return 6'd0;
  endfunction

  exe_mem_t b;
  ho_t      hx;
  st_t      sx;
  bit       stx;
  bit       got;

  initial begin
    rst = 1'b1;
    es_to_ms_valid = 1'b0;
    exe_mem_bus_in = '0;
    exception_code_em = '0;
    exception_stalled = 1'b0;
    rand_ws = 0;
    ws_force = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_allowin", ms_allowin, 1'b1);
    chk("rst_to_ws", ms_to_ws_valid, 1'b0);
    chk("rst_wb_bus", mem_wb_bus_out, '0);
    chk("rst_id_bus", mem_id_data_bus, '0);
    chk("rst_dmem", {dmem_wreq, dmem_waddr, dmem_wdata,
                     dmem_wstrb}, '0);
    chk("rst_csr", {csr_we, csr_waddr, csr_wdata}, '0);
    chk("rst_exc", exception_code_mw, '0);
    rst = 1'b0;
    idle(1);

    // SB to 0x1003, ack on third request cycle.
    ack_fixed = 2;
    b = '0;
    b.alu_result = 32'h0000_1003;
    b.wb_data = 32'h0000_00AB;
    b.mem_we = 1'b1;
    b.mem_size = 3'b011;
    b.exe_pc = 32'h0000_0400;
    send(b, 6'd0, 1);
    got = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (dmem_wreq) begin
        got = 1;
        break;
      end
    end
    chk("sb_wreq_seen", got, 1'b1);
    chk("sb_waddr", dmem_waddr, 32'h0000_1000);
    chk("sb_wstrb", dmem_wstrb, 4'b1000);
    chk("sb_wdata", dmem_wdata, 32'hABAB_ABAB);
    got = 0;
    for (int i = 0; i < 50; i++) begin
      if (dmem_wack) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    chk("sb_ack_seen", got, 1'b1);
    @(negedge clk);
    chk("sb_handoff_next", ms_to_ws_valid, 1'b1);
    ack_fixed = -1;
    idle(3);

    // SW misaligned: exception, no store, rd_wen dropped.
    b = '0;
    b.alu_result = 32'h0000_1002;
    b.mem_we = 1'b1;
    b.rd_wen = 1'b1;
    b.rd = 5'd9;
    b.mem_size = 3'b000;
    send(b, 6'd0, 1);
    @(negedge clk);
    chk("sw_mis_exc", exception_code_mw, 6'b100110);
    chk("sw_mis_nowreq", dmem_wreq, 1'b0);
    chk("sw_mis_rdwen", mem_wb_bus_out[32], 1'b0);
    idle(3);

    // CSRRS old 0x0F, op1 0xF0.
    b = '0;
    b.wb_sel = 3'b100;
    b.alu_result = 32'h0000_000F;
    b.op1_data = 32'h0000_00F0;
    b.csr_cmd = 4'b0100;
    b.csr_addr = 12'h300;
    b.rd_wen = 1'b1;
    b.rd = 5'd4;
    send(b, 6'd0, 1);
    @(negedge clk);
    chk("csrrs_we", csr_we, 1'b1);
    chk("csrrs_wdata", csr_wdata, 32'h0000_00FF);
    @(negedge clk);
    chk("csrrs_pulse_end", csr_we, 1'b0);
    idle(2);

    // Load forwarding value.
    b = '0;
    b.wb_sel = 3'b010;
    b.mem_re = 1'b1;
    b.mem_rdata_ext = 32'hFFFF_FF80;
    b.rd_wen = 1'b1;
    b.rd = 5'd7;
    send(b, 6'd0, 1);
    @(negedge clk);
    chk("ld_id_bus", mem_id_data_bus,
        {32'hFFFF_FF80, 1'b1, 5'd7});
    idle(3);

    // Downstream stall for 4 cycles.
    ws_force = 1'b0;
    b = '0;
    b.wb_sel = 3'b001;
    b.alu_result = 32'h1234_5678;
    b.rd_wen = 1'b1;
    b.rd = 5'd3;
    b.exe_pc = 32'h0000_0100;
    model(b, 6'd0, hx, stx, sx);
    send(b, 6'd0, 1);
    repeat (4) begin
      @(negedge clk);
      chk("stall_allowin", ms_allowin, 1'b0);
      chk("stall_bus", mem_wb_bus_out, hx.wb);
    end
    @(posedge clk);
    #1;
    ws_force = 1'b1;
    idle(3);

    // Flush while an ALU op waits.
    ws_force = 1'b0;
    b.rd = 5'd11;
    send(b, 6'd0, 0);
    exception_stalled = 1'b1;
    idle(1);
    exception_stalled = 1'b0;
    @(negedge clk);
    chk("flush_idle_valid", ms_to_ws_valid, 1'b0);
    chk("flush_idle_allow", ms_allowin, 1'b1);
    @(posedge clk);
    #1;
    ws_force = 1'b1;
    idle(2);

    // Flush during REQ.
    ack_fixed = 4;
    b = '0;
    b.mem_we = 1'b1;
    b.alu_result = 32'h0000_2000;
    b.wb_data = 32'hCAFE_F00D;
    send(b, 6'd0, 0);
    got = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (dmem_wreq) begin
        got = 1;
        break;
      end
    end
    chk("fl_wreq_seen", got, 1'b1);
    idle(1);
    exception_stalled = 1'b1;
    idle(1);
    exception_stalled = 1'b0;
    got = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("fl_wreq_held", dmem_wreq, 1'b1);
      chk("fl_allowin", ms_allowin, 1'b0);
      if (dmem_wack) begin
        got = 1;
        break;
      end
    end
    chk("fl_ack_seen", got, 1'b1);
    @(negedge clk);
    chk("fl_no_handoff", ms_to_ws_valid, 1'b0);
    chk("fl_allow_after", ms_allowin, 1'b1);
    chk("fl_wreq_off", dmem_wreq, 1'b0);
    idle(2);

    // Reset in the middle of a request.
    ack_fixed = 20;
    b.alu_result = 32'h0000_3000;
    send(b, 6'd0, 0);
    got = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (dmem_wreq) begin
        got = 1;
        break;
      end
    end
    chk("rr_wreq_seen", got, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("rr_wreq_drop", dmem_wreq, 1'b0);
    chk("rr_allowin", ms_allowin, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ack_fixed = -1;
    idle(2);

    // Randomized traffic.
    rand_ws = 1;
    for (int n = 0; n < 300; n++) begin
      idle($urandom_range(0, 2));
      send(gen(), gen_em(), 1);
    end
    for (int i = 0; i < 500; i++) begin
      if (ho_q.size() == 0 && st_q.size() == 0) break;
      idle(1);
    end
    chk("drain_ho", ho_q.size(), 0);
    chk("drain_st", st_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
